// File: rtl/mima_pkg.sv
// Shared encodings for the MIMA control unit: opcodes, FSM states,
// datapath select codes and the instruction classes produced by the decoder.
package mima_pkg;

  localparam logic [3:0] OP_LDC  = 4'h0;
  localparam logic [3:0] OP_LDV  = 4'h1;
  localparam logic [3:0] OP_STV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_EQL  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JMN  = 4'h9;
  localparam logic [3:0] OP_LDIV = 4'hA;
  localparam logic [3:0] OP_STIV = 4'hB;
  localparam logic [3:0] OP_EXT  = 4'hF;

  localparam logic [3:0] EXT_HALT = 4'h0;
  localparam logic [3:0] EXT_NOT  = 4'h1;
  localparam logic [3:0] EXT_RAR  = 4'h2;

  localparam logic [1:0] SAR_SRC_IAR = 2'd0;
  localparam logic [1:0] SAR_SRC_IR  = 2'd1;
  localparam logic [1:0] SAR_SRC_SDR = 2'd2;

  localparam logic [1:0] ACC_SRC_ALU = 2'd0;
  localparam logic [1:0] ACC_SRC_SDR = 2'd1;
  localparam logic [1:0] ACC_SRC_IR  = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_AND = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_XOR = 3'd3;
  localparam logic [2:0] ALU_EQL = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_RAR = 3'd6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FETCH_RD,
    ST_DECODE,
    ST_OPRD,
    ST_EXEC,
    ST_PTR_RD,
    ST_PTR_LD,
    ST_WR,
    ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_CONST,
    CLS_JUMP,
    CLS_JUMPN,
    CLS_MEM_ALU,
    CLS_STORE,
    CLS_IND_LOAD,
    CLS_IND_STORE,
    CLS_ACC_ALU,
    CLS_HALT,
    CLS_NOP
  } instr_class_t;

endpackage

// File: rtl/mima_op_decode.sv
// Combinational instruction classifier: {opcode, ext_op} -> class, ALU
// operation, and whether the final ACC load takes SDR rather than the ALU.
module mima_op_decode
  import mima_pkg::*;
(
  input  logic [3:0]   i_op,
  input  logic [3:0]   i_ext,
  output instr_class_t o_cls,
  output logic [2:0]   o_alu_op,
  output logic         o_ld_sdr
);

  always_comb begin
    o_cls    = CLS_NOP;
    o_alu_op = ALU_ADD;
    o_ld_sdr = 1'b0;
    case (i_op)
      OP_LDC:  o_cls = CLS_CONST;
      OP_LDV: begin
        o_cls    = CLS_MEM_ALU;
        o_ld_sdr = 1'b1;
      end
      OP_STV:  o_cls = CLS_STORE;
      OP_ADD, OP_AND, OP_OR, OP_XOR, OP_EQL: begin
        o_cls    = CLS_MEM_ALU;
        // ALU codes are laid out in opcode order starting at ADD
        o_alu_op = 3'(i_op - OP_ADD);
      end
      OP_JMP:  o_cls = CLS_JUMP;
      OP_JMN:  o_cls = CLS_JUMPN;
      OP_LDIV: begin
        o_cls    = CLS_IND_LOAD;
        o_ld_sdr = 1'b1;
      end
      OP_STIV: o_cls = CLS_IND_STORE;
      OP_EXT: begin
        case (i_ext)
          EXT_HALT: o_cls = CLS_HALT;
          EXT_NOT: begin
            o_cls    = CLS_ACC_ALU;
            o_alu_op = ALU_NOT;
          end
          EXT_RAR: begin
            o_cls    = CLS_ACC_ALU;
            o_alu_op = ALU_RAR;
          end
          default: o_cls = CLS_NOP;
        endcase
      end
      default: o_cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/mima_ctrl_unit.sv
// MIMA control unit: fetch/decode/execute sequencer driving datapath strobes
// and a req/ack memory port with a per-transaction timeout that halts on fault.
module mima_ctrl_unit
  import mima_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic [3:0] ext_op,
  input  logic       acc_neg,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       sar_ld,
  output logic [1:0] sar_src,
  output logic       sdr_ld_mem,
  output logic       sdr_ld_acc,
  output logic       ir_ld,
  output logic       iar_inc,
  output logic       iar_ld,
  output logic       acc_ld,
  output logic [1:0] acc_src,
  output logic [2:0] alu_op,
  output logic       halted,
  output logic       fault
);

  localparam logic [TO_W-1:0] TO_LAST =
    (MEM_TIMEOUT == 0) ? '0 : TO_W'(MEM_TIMEOUT - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [7:0]      r_cur_op;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_fault;

  logic [7:0]      w_dec_op;
  instr_class_t    w_cls;
  logic [2:0]      w_alu_op;
  logic            w_ld_sdr;
  logic            w_req_state;
  logic            w_expire;

  // DECODE sees the freshly loaded IR; later states use the captured opcode
  assign w_dec_op = (r_state == ST_DECODE) ? {opcode, ext_op} : r_cur_op;

  mima_op_decode u_dec (
    .i_op     (w_dec_op[7:4]),
    .i_ext    (w_dec_op[3:0]),
    .o_cls    (w_cls),
    .o_alu_op (w_alu_op),
    .o_ld_sdr (w_ld_sdr)
  );

  assign w_req_state = (r_state == ST_FETCH_RD) || (r_state == ST_OPRD) ||
                       (r_state == ST_PTR_RD)   || (r_state == ST_WR);
  assign w_expire    = (MEM_TIMEOUT != 0) && w_req_state && !mem_ack &&
                       (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cur_op <= '0;
      r_to_cnt <= '0;
      r_fault  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_DECODE) begin
        r_cur_op <= {opcode, ext_op};
      end
      // Any transition clears the count, so each request state starts at zero
      if (r_state != w_state_next) begin
        r_to_cnt <= '0;
      end else if (w_req_state && !mem_ack) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_expire) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign halted = (r_state == ST_HALT);
  assign fault  = r_fault;

  always_comb begin
    w_state_next = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    sar_ld       = 1'b0;
    sar_src      = SAR_SRC_IAR;
    sdr_ld_mem   = 1'b0;
    sdr_ld_acc   = 1'b0;
    ir_ld        = 1'b0;
    iar_inc      = 1'b0;
    iar_ld       = 1'b0;
    acc_ld       = 1'b0;
    acc_src      = ACC_SRC_ALU;
    alu_op       = ALU_ADD;
    case (r_state)
      ST_IDLE: begin
        if (run) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        sar_ld       = 1'b1;
        sar_src      = SAR_SRC_IAR;
        w_state_next = ST_FETCH_RD;
      end
      ST_FETCH_RD: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_ld        = 1'b1;
          iar_inc      = 1'b1;
          w_state_next = ST_DECODE;
        end else if (w_expire) begin
          w_state_next = ST_HALT;
        end
      end
      ST_DECODE: begin
        w_state_next = ST_FETCH;
        case (w_cls)
          CLS_CONST: begin
            acc_ld  = 1'b1;
            acc_src = ACC_SRC_IR;
          end
          CLS_JUMP:  iar_ld = 1'b1;
          CLS_JUMPN: iar_ld = acc_neg;
          CLS_MEM_ALU: begin
            sar_ld       = 1'b1;
            sar_src      = SAR_SRC_IR;
            w_state_next = ST_OPRD;
          end
          CLS_STORE: begin
            sar_ld       = 1'b1;
            sar_src      = SAR_SRC_IR;
            sdr_ld_acc   = 1'b1;
            w_state_next = ST_WR;
          end
          CLS_IND_LOAD, CLS_IND_STORE: begin
            sar_ld       = 1'b1;
            sar_src      = SAR_SRC_IR;
            w_state_next = ST_PTR_RD;
          end
          CLS_ACC_ALU: begin
            acc_ld = 1'b1;
            alu_op = w_alu_op;
          end
          CLS_HALT: w_state_next = ST_HALT;
          default:  w_state_next = ST_FETCH;
        endcase
      end
      ST_OPRD, ST_PTR_RD: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          sdr_ld_mem   = 1'b1;
          w_state_next = (r_state == ST_OPRD) ? ST_EXEC : ST_PTR_LD;
        end else if (w_expire) begin
          w_state_next = ST_HALT;
        end
      end
      ST_EXEC: begin
        acc_ld = 1'b1;
        if (w_ld_sdr) begin
          acc_src = ACC_SRC_SDR;
        end else begin
          alu_op = w_alu_op;
        end
        w_state_next = ST_FETCH;
      end
      ST_PTR_LD: begin
        sar_ld  = 1'b1;
        sar_src = SAR_SRC_SDR;
        if (w_cls == CLS_IND_STORE) begin
          sdr_ld_acc   = 1'b1;
          w_state_next = ST_WR;
        end else begin
          w_state_next = ST_OPRD;
        end
      end
      ST_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          w_state_next = ST_FETCH;
        end else if (w_expire) begin
          w_state_next = ST_HALT;
        end
      end
      ST_HALT: w_state_next = ST_HALT;
      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mima_ctrl_unit.sv
// Directed cycle-by-cycle bench for mima_ctrl_unit; a second instance with a
// short timeout covers the fault path.
module tb_mima_ctrl_unit;
  import mima_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [3:0] opcode;
  logic [3:0] ext_op;
  logic       acc_neg;
  logic       mem_ack;

  logic       req1, we1, sl1, sm1, sa1, il1, inc1, jl1, al1, h1, f1;
  logic [1:0] ss1, as1;
  logic [2:0] op1;
  logic       req2, we2, sl2, sm2, sa2, il2, inc2, jl2, al2, h2, f2;
  logic [1:0] ss2, as2;
  logic [2:0] op2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mima_ctrl_unit dut1 (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .ext_op(ext_op),
    .acc_neg(acc_neg), .mem_ack(mem_ack), .mem_req(req1), .mem_we(we1),
    .sar_ld(sl1), .sar_src(ss1), .sdr_ld_mem(sm1), .sdr_ld_acc(sa1),
    .ir_ld(il1), .iar_inc(inc1), .iar_ld(jl1), .acc_ld(al1), .acc_src(as1),
    .alu_op(op1), .halted(h1), .fault(f1)
  );

  mima_ctrl_unit #(.MEM_TIMEOUT(4), .TO_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .ext_op(ext_op),
    .acc_neg(acc_neg), .mem_ack(mem_ack), .mem_req(req2), .mem_we(we2),
    .sar_ld(sl2), .sar_src(ss2), .sdr_ld_mem(sm2), .sdr_ld_acc(sa2),
    .ir_ld(il2), .iar_inc(inc2), .iar_ld(jl2), .acc_ld(al2), .acc_src(as2),
    .alu_op(op2), .halted(h2), .fault(f2)
  );

  // Field order: req we sar_ld sar_src sdr_mem sdr_acc ir_ld iar_inc iar_ld acc_ld acc_src alu_op halted fault
  logic [17:0] o1, o2;
  assign o1 = {req1, we1, sl1, ss1, sm1, sa1, il1, inc1, jl1, al1, as1, op1, h1, f1};
  assign o2 = {req2, we2, sl2, ss2, sm2, sa2, il2, inc2, jl2, al2, as2, op2, h2, f2};

  localparam logic [17:0] E_NONE        = 18'b0_0_0_00_0_0_0_0_0_0_00_000_0_0;
  localparam logic [17:0] E_FETCH       = 18'b0_0_1_00_0_0_0_0_0_0_00_000_0_0;
  localparam logic [17:0] E_RD_WAIT     = 18'b1_0_0_00_0_0_0_0_0_0_00_000_0_0;
  localparam logic [17:0] E_WR          = 18'b1_1_0_00_0_0_0_0_0_0_00_000_0_0;
  localparam logic [17:0] E_FETCH_ACK   = 18'b1_0_0_00_0_0_1_1_0_0_00_000_0_0;
  localparam logic [17:0] E_RD_ACK      = 18'b1_0_0_00_1_0_0_0_0_0_00_000_0_0;
  localparam logic [17:0] E_LDC         = 18'b0_0_0_00_0_0_0_0_0_1_10_000_0_0;
  localparam logic [17:0] E_JMP         = 18'b0_0_0_00_0_0_0_0_1_0_00_000_0_0;
  localparam logic [17:0] E_SAR_IR      = 18'b0_0_1_01_0_0_0_0_0_0_00_000_0_0;
  localparam logic [17:0] E_SAR_IR_ACC  = 18'b0_0_1_01_0_1_0_0_0_0_00_000_0_0;
  localparam logic [17:0] E_SAR_SDR     = 18'b0_0_1_10_0_0_0_0_0_0_00_000_0_0;
  localparam logic [17:0] E_SAR_SDR_ACC = 18'b0_0_1_10_0_1_0_0_0_0_00_000_0_0;
  localparam logic [17:0] E_ACC_SDR     = 18'b0_0_0_00_0_0_0_0_0_1_01_000_0_0;
  localparam logic [17:0] E_HALT        = 18'b0_0_0_00_0_0_0_0_0_0_00_000_1_0;
  localparam logic [17:0] E_HALT_FAULT  = 18'b0_0_0_00_0_0_0_0_0_0_00_000_1_1;

  function automatic logic [17:0] e_alu(input logic [2:0] op);
    return {13'b0_0_0_00_0_0_0_0_0_1_00, op, 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive ack, sample mid-cycle, advance to just after the next edge
  task automatic step(input string tag, input logic [17:0] exp, input logic ack, input bit use2);
    mem_ack = ack;
    #1;
    if (use2) chk(tag, 32'(o2), 32'(exp));
    else      chk(tag, 32'(o1), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] op, input logic [3:0] ext, input int waits);
    opcode = op;
    ext_op = ext;
    step("fetch", E_FETCH, 1'b1, 1'b0);
    for (int i = 0; i < waits; i++) step("fetch_rd_wait", E_RD_WAIT, 1'b0, 1'b0);
    step("fetch_rd_ack", E_FETCH_ACK, 1'b1, 1'b0);
  endtask

  // After DECODE the IR inputs are scrambled so later states must use cur_op
  task automatic decode(input string tag, input logic [17:0] exp);
    step(tag, exp, 1'b1, 1'b0);
    opcode = 4'hC;
    ext_op = 4'h7;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = 4'h0; ext_op = 4'h0;
    acc_neg = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) step("reset", E_NONE, 1'b1, 1'b0);
    chk("reset_state", 32'(dut1.r_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    step("idle_norun", E_NONE, 1'b1, 1'b0);
    step("idle_norun", E_NONE, 1'b1, 1'b0);
    chk("idle_state", 32'(dut1.r_state), 32'(ST_IDLE));
    run = 1'b1;
    step("idle_run", E_NONE, 1'b1, 1'b0);

    fetch(OP_LDC, 4'h0, 0);
    decode("ldc_dec", E_LDC);

    fetch(OP_ADD, 4'h0, 4);
    decode("add_dec", E_SAR_IR);
    for (int i = 0; i < 4; i++) step("add_oprd_wait", E_RD_WAIT, 1'b0, 1'b0);
    step("add_oprd_ack", E_RD_ACK, 1'b1, 1'b0);
    step("add_exec", e_alu(ALU_ADD), 1'b1, 1'b0);

    fetch(OP_XOR, 4'h0, 0);
    decode("xor_dec", E_SAR_IR);
    step("xor_oprd", E_RD_ACK, 1'b1, 1'b0);
    step("xor_exec", e_alu(ALU_XOR), 1'b1, 1'b0);

    fetch(OP_JMN, 4'h0, 0);
    decode("jmn_pos", E_NONE);
    acc_neg = 1'b1;
    fetch(OP_JMN, 4'h0, 0);
    decode("jmn_neg", E_JMP);
    acc_neg = 1'b0;
    fetch(OP_JMP, 4'h0, 0);
    decode("jmp_dec", E_JMP);

    fetch(OP_LDIV, 4'h0, 0);
    decode("ldiv_dec", E_SAR_IR);
    step("ldiv_ptr_rd", E_RD_ACK, 1'b1, 1'b0);
    step("ldiv_ptr_ld", E_SAR_SDR, 1'b1, 1'b0);
    step("ldiv_oprd", E_RD_ACK, 1'b1, 1'b0);
    step("ldiv_exec", E_ACC_SDR, 1'b1, 1'b0);

    fetch(OP_STIV, 4'h0, 0);
    decode("stiv_dec", E_SAR_IR);
    step("stiv_ptr_rd", E_RD_ACK, 1'b1, 1'b0);
    step("stiv_ptr_ld", E_SAR_SDR_ACC, 1'b1, 1'b0);
    step("stiv_wr", E_WR, 1'b1, 1'b0);

    fetch(OP_STV, 4'h0, 0);
    decode("stv_dec", E_SAR_IR_ACC);
    step("stv_wr_wait", E_WR, 1'b0, 1'b0);
    step("stv_wr_wait", E_WR, 1'b0, 1'b0);
    step("stv_wr_ack", E_WR, 1'b1, 1'b0);

    fetch(OP_EXT, EXT_NOT, 0);
    decode("not_dec", e_alu(ALU_NOT));
    fetch(OP_EXT, EXT_RAR, 0);
    decode("rar_dec", e_alu(ALU_RAR));
    fetch(4'hC, 4'h0, 0);
    decode("nop_c_dec", E_NONE);
    fetch(OP_EXT, 4'h5, 0);
    decode("nop_f5_dec", E_NONE);
    step("after_nop_fetch", E_FETCH, 1'b1, 1'b0);

    opcode = OP_EXT; ext_op = EXT_HALT;
    step("halt_fetch_rd", E_FETCH_ACK, 1'b1, 1'b0);
    decode("halt_dec", E_NONE);
    run = 1'b0;
    step("halted_run0", E_HALT, 1'b1, 1'b0);
    run = 1'b1;
    step("halted_run1", E_HALT, 1'b1, 1'b0);
    chk("halt_state", 32'(dut1.r_state), 32'(ST_HALT));

    // Timeout expiry on the short-timeout instance
    rst_n = 1'b0; run = 1'b0;
    step("to_reset", E_NONE, 1'b0, 1'b1);
    rst_n = 1'b1; run = 1'b1;
    step("to_idle", E_NONE, 1'b0, 1'b1);
    step("to_fetch", E_FETCH, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("to_wait", E_RD_WAIT, 1'b0, 1'b1);
    step("to_fault", E_HALT_FAULT, 1'b1, 1'b1);
    step("to_fault_sticky", E_HALT_FAULT, 1'b0, 1'b1);

    // Ack exactly in the expiry cycle completes normally
    rst_n = 1'b0;
    step("toack_reset", E_NONE, 1'b0, 1'b1);
    rst_n = 1'b1;
    step("toack_idle", E_NONE, 1'b0, 1'b1);
    step("toack_fetch", E_FETCH, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("toack_wait", E_RD_WAIT, 1'b0, 1'b1);
    opcode = OP_LDC; ext_op = 4'h0;
    step("toack_ack", E_FETCH_ACK, 1'b1, 1'b1);
    step("toack_ldc", E_LDC, 1'b1, 1'b1);

    // Reset asserted in the middle of a write request
    rst_n = 1'b0;
    step("wr_reset", E_NONE, 1'b0, 1'b0);
    rst_n = 1'b1;
    step("wr_idle", E_NONE, 1'b1, 1'b0);
    fetch(OP_STV, 4'h0, 0);
    decode("wr_stv_dec", E_SAR_IR_ACC);
    mem_ack = 1'b0;
    #1;
    chk("wr_req", 32'(o1), 32'(E_WR));
    #1;
    rst_n = 1'b0;
    #1;
    chk("wr_abort_outputs", 32'(o1), 32'(E_NONE));
    chk("wr_abort_state", 32'(dut1.r_state), 32'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
